// File: rtl/spi_switch_arb_pkg.sv
// spi_switch_arb_pkg
//   Shared types and helpers for the arbitrated SPI wire switch.
//   - sw_state_e : arbitration FSM states
//   - idx_w()    : width of a port index for a given port count
//   - rr_dist()  : round-robin distance of a port from the slot after last_owner
package spi_switch_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2,
    ST_BLOCK = 2'd3
  } sw_state_e;

  // Port index width; at least one bit so PORTS=2 still has a usable index.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // 0 for the port right after last, n-1 for last itself.
  function automatic int rr_dist(input int idx, input int last, input int n);
    return (idx + n - last - 1) % n;
  endfunction

endpackage

// File: rtl/spi_switch_arb_if.sv
// spi_switch_arb_if
//   Bundle between the per-port SPI masters, the switch and the shared pins.
//   Arbitration : req (in), grant/owner/busy/timeout (out)
//   Shared bus  : mosi/sck/ss_L (out), miso (in)
//   Per port    : mosi_ports/sck_ports/ss_L_ports (in), miso_ports (out)
//   modport slave is the switch side; modport master is the masters/pins side.
interface spi_switch_arb_if
  import spi_switch_arb_pkg::*;
#(
  parameter int PORTS = 4
);
  localparam int OW = idx_w(PORTS);

  logic [PORTS-1:0] req;
  logic [PORTS-1:0] grant;
  logic [OW-1:0]    owner;
  logic             busy;
  logic             timeout;

  logic             mosi;
  logic             miso;
  logic             sck;
  logic             ss_L;

  logic [PORTS-1:0] mosi_ports;
  logic [PORTS-1:0] miso_ports;
  logic [PORTS-1:0] sck_ports;
  logic [PORTS-1:0] ss_L_ports;

  modport slave (
    input  req, miso, mosi_ports, sck_ports, ss_L_ports,
    output grant, owner, busy, timeout, mosi, sck, ss_L, miso_ports
  );

  modport master (
    output req, miso, mosi_ports, sck_ports, ss_L_ports,
    input  grant, owner, busy, timeout, mosi, sck, ss_L, miso_ports
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter
//   Combinational round-robin picker.
//   req        : per-port request
//   mask       : ports excluded from this pick
//   last_owner : previous winner; search starts at last_owner+1, wraps
//   valid      : some unmasked port is requesting
//   winner     : index of the chosen port (0 when !valid)
module spi_rr_arbiter
  import spi_switch_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int OW    = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] mask,
  input  logic [OW-1:0]    last_owner,
  output logic             valid,
  output logic [OW-1:0]    winner
);

  logic [PORTS-1:0] elig;
  int               best_d;

  assign elig = req & ~mask;

  // Keep the eligible port with the smallest distance from last_owner+1.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    best_d = PORTS;
    for (int i = 0; i < PORTS; i++) begin
      if (elig[i] && (rr_dist(i, int'(last_owner), PORTS) < best_d)) begin
        best_d = rr_dist(i, int'(last_owner), PORTS);
        valid  = 1'b1;
        winner = OW'(i);
      end
    end
  end

endmodule

// File: rtl/spi_switch_arb.sv
// spi_switch_arb
//   Connects PORTS SPI masters to one shared SPI bus. Ownership is granted by
//   a round-robin request/grant handshake; the bus is parked for GUARD_CYCLES
//   between owners, and an optional MAX_HOLD limit revokes a stuck owner.
//   clk, rst : clock and synchronous active-high reset
//   sw       : arbitration handshake, shared bus and per-port SPI wires
//   Parameters: PORTS (2..16), GUARD_CYCLES (>=1), MAX_HOLD (0 = no limit),
//   CPOL (parked sck level).
module spi_switch_arb
  import spi_switch_arb_pkg::*;
#(
  parameter int   PORTS        = 4,
  parameter int   GUARD_CYCLES = 2,
  parameter int   MAX_HOLD     = 0,
  parameter logic CPOL         = 1'b0
) (
  input logic             clk,
  input logic             rst,
  spi_switch_arb_if.slave sw
);

  localparam int OW = idx_w(PORTS);
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  sw_state_e        state_q, nxt_state;
  logic [OW-1:0]    owner_q, nxt_owner;
  logic [OW-1:0]    last_q,  nxt_last;
  logic [PORTS-1:0] grant_q, nxt_grant;
  logic [PORTS-1:0] mask_q,  nxt_mask;
  logic             busy_q;
  logic [HW-1:0]    hold_q;
  logic [GW-1:0]    guard_q;

  logic [PORTS-1:0] sel;
  logic [PORTS-1:0] miso_route;
  logic [PORTS-1:0] mask_live;
  logic             own_req;
  logic             hold_hit;
  logic             guard_done;
  logic             arb_vld;
  logic [OW-1:0]    arb_win;

  spi_rr_arbiter #(
    .PORTS (PORTS),
    .OW    (OW)
  ) u_arb (
    .req        (sw.req),
    .mask       (mask_q),
    .last_owner (last_q),
    .valid      (arb_vld),
    .winner     (arb_win)
  );

  // A revoked port stays masked only while it keeps requesting; the first
  // cycle its req is low releases it.
  assign mask_live  = mask_q & sw.req;
  assign own_req    = |(sel & sw.req);
  assign hold_hit   = (MAX_HOLD != 0) && (state_q == ST_OWN) &&
                      (hold_q == HW'(MAX_HOLD));
  assign guard_done = (guard_q == GW'(GUARD_CYCLES - 1));

  always_comb begin
    nxt_state = state_q;
    nxt_owner = owner_q;
    nxt_last  = last_q;
    nxt_mask  = mask_live;
    nxt_grant = '0;
    case (state_q)
      // BLOCK arbitrates like IDLE (mask applied by the picker) and falls
      // back to IDLE once the revoked port lets go of req.
      ST_IDLE, ST_BLOCK: begin
        if ((state_q == ST_BLOCK) && !(|mask_live)) begin
          nxt_state = ST_IDLE;
        end else if (arb_vld) begin
          nxt_state = ST_OWN;
          nxt_owner = arb_win;
          nxt_last  = arb_win;
        end
      end
      ST_OWN: begin
        if (!own_req) begin
          nxt_state = ST_GUARD;
        end else if (hold_hit) begin
          nxt_state = ST_GUARD;
          nxt_mask  = mask_live | (sel & sw.req);
        end
      end
      ST_GUARD: begin
        if (guard_done) nxt_state = (|mask_live) ? ST_BLOCK : ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
    for (int i = 0; i < PORTS; i++) begin
      nxt_grant[i] = (nxt_state == ST_OWN) && (nxt_owner == OW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OW'(PORTS - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      mask_q  <= '0;
      hold_q  <= '0;
      guard_q <= '0;
    end else begin
      state_q <= nxt_state;
      owner_q <= nxt_owner;
      last_q  <= nxt_last;
      grant_q <= nxt_grant;
      busy_q  <= (nxt_state == ST_OWN);
      mask_q  <= nxt_mask;
      // Loaded with 1 on the edge that enters OWN, so the first owned cycle
      // reads 1 and the grant lasts exactly MAX_HOLD cycles.
      hold_q  <= (state_q == ST_OWN)   ? hold_q + 1'b1  : HW'(1);
      guard_q <= (state_q == ST_GUARD) ? guard_q + 1'b1 : '0;
    end
  end

  // Routing: per-port select from the registered owner; nothing is selected
  // while not busy, which parks every shared output.
  for (genvar p = 0; p < PORTS; p++) begin : g_route
    assign sel[p]        = busy_q && (owner_q == OW'(p));
    assign miso_route[p] = sel[p] & sw.miso;
  end

  assign sw.miso_ports = miso_route;
  assign sw.mosi       = |(sel & sw.mosi_ports);
  assign sw.sck        = busy_q ? |(sel & sw.sck_ports) : CPOL;
  assign sw.ss_L       = ~|(sel & ~sw.ss_L_ports);

  assign sw.grant   = grant_q;
  assign sw.owner   = owner_q;
  assign sw.busy    = busy_q;
  assign sw.timeout = hold_hit & own_req;

endmodule
